// File: rtl/stack_ctrl.sv
// stack_ctrl: command/response controller for a single-port-per-direction stack memory.
// PUSH writes through the memory write port in the accept cycle, POP/PEEK read the
// top word through a registered read address, and every non-NOP command returns
// exactly one response that is held until the consumer takes it.
module stack_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_in_address,
  output logic [DATA_WIDTH-1:0] mem_in_data,
  output logic [ADDR_WIDTH-1:0] mem_out_address,
  input  logic [DATA_WIDTH-1:0] mem_out_data,
  output logic [ADDR_WIDTH:0]   sp_count,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  // Occupancy constants: depth is one past the largest address, so the count
  // register carries one extra bit to represent a completely full stack.
  localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_next_s;
  logic [ADDR_WIDTH:0]   sp_count_r;
  logic [ADDR_WIDTH:0]   sp_count_next_s;
  logic [ADDR_WIDTH-1:0] mem_out_address_r;
  logic [ADDR_WIDTH-1:0] mem_out_address_next_s;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic [DATA_WIDTH-1:0] rsp_data_next_s;
  logic                  rsp_err_r;
  logic                  rsp_err_next_s;
  logic                  push_ok_s;
  logic                  full_s;
  logic                  empty_s;
  logic [ADDR_WIDTH-1:0] top_address_s;

  // Occupancy decodes and the address of the current top-of-stack word.
  // With a full stack the low count bits are zero, so subtracting one lands
  // on the last address without needing the extra count bit.
  always_comb begin
    full_s        = (sp_count_r == DEPTH);
    empty_s       = (sp_count_r == CNT_ZERO);
    top_address_s = sp_count_r[ADDR_WIDTH-1:0] - ADDR_ONE;
  end

  // Next-state and next-register computation for the command/response FSM.
  always_comb begin
    state_next_s           = state_r;
    sp_count_next_s        = sp_count_r;
    mem_out_address_next_s = mem_out_address_r;
    rsp_data_next_s        = rsp_data_r;
    rsp_err_next_s         = rsp_err_r;
    push_ok_s              = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              rsp_data_next_s = DATA_ZERO;
              state_next_s    = RESP;
              if (!full_s) begin
                push_ok_s       = 1'b1;
                sp_count_next_s = sp_count_r + CNT_ONE;
                rsp_err_next_s  = 1'b0;
              end else begin
                rsp_err_next_s  = 1'b1;
              end
            end
            OP_POP, OP_PEEK: begin
              if (!empty_s) begin
                mem_out_address_next_s = top_address_s;
                state_next_s           = READ;
                if (cmd_op == OP_POP) begin
                  sp_count_next_s = sp_count_r - CNT_ONE;
                end else begin
                  sp_count_next_s = sp_count_r;
                end
              end else begin
                rsp_data_next_s = DATA_ZERO;
                rsp_err_next_s  = 1'b1;
                state_next_s    = RESP;
              end
            end
            OP_NOP: begin
              state_next_s = IDLE;
            end
            default: begin
              state_next_s = IDLE;
            end
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        // The read address was registered on accept; memory data is valid now.
        rsp_data_next_s = mem_out_data;
        rsp_err_next_s  = 1'b0;
        state_next_s    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      sp_count_r        <= CNT_ZERO;
      mem_out_address_r <= ADDR_ZERO;
      rsp_data_r        <= DATA_ZERO;
      rsp_err_r         <= 1'b0;
    end else begin
      state_r           <= state_next_s;
      sp_count_r        <= sp_count_next_s;
      mem_out_address_r <= mem_out_address_next_s;
      rsp_data_r        <= rsp_data_next_s;
      rsp_err_r         <= rsp_err_next_s;
    end
  end

  // Output drive: handshakes decode the state, the write port is qualified
  // by reset so no write can escape while reset is asserted.
  always_comb begin
    cmd_ready       = (state_r == IDLE);
    rsp_valid       = (state_r == RESP);
    rsp_data        = rsp_data_r;
    rsp_err         = rsp_err_r;
    mem_we          = push_ok_s & reset_n;
    mem_in_address  = sp_count_r[ADDR_WIDTH-1:0];
    mem_in_data     = cmd_data;
    mem_out_address = mem_out_address_r;
    sp_count        = sp_count_r;
    full            = full_s;
    empty           = empty_s;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with a queue-based reference
// model, a per-cycle compare process and a set of literal expectations.
module tb_stack_ctrl;

  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] PEEK = 2'b11;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_data = 12'h000;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_in_address;
  logic [DW-1:0] mem_in_data;
  logic [AW-1:0] mem_out_address;
  logic [DW-1:0] mem_out_data;
  logic [AW:0]   sp_count;
  logic          full;
  logic          empty;

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_in_address(mem_in_address), .mem_in_data(mem_in_data),
    .mem_out_address(mem_out_address), .mem_out_data(mem_out_data),
    .sp_count(sp_count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // Stack memory: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  assign mem_out_data = mem[mem_out_address];
  always @(posedge clock) if (mem_we === 1'b1) mem[mem_in_address] <= mem_in_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue; a response appears a fixed number
  // of cycles after accept and is held until taken.
  logic [DW-1:0] stk[$];
  bit            m_busy = 1'b0;
  bit            m_rv   = 1'b0;
  int            m_wait = 0;
  logic [DW-1:0] m_data = 12'h000;
  logic          m_err  = 1'b0;
  logic [AW-1:0] m_addr = 8'h00;

  always @(posedge clock) begin
    if (!reset_n) begin
      stk.delete();
      m_busy = 1'b0; m_rv = 1'b0; m_wait = 0;
      m_data = 12'h000; m_err = 1'b0; m_addr = 8'h00;
    end else if (m_busy) begin
      if (m_rv) begin
        if (rsp_ready) begin m_rv = 1'b0; m_busy = 1'b0; end
      end else begin
        m_wait--;
        if (m_wait == 0) m_rv = 1'b1;
      end
    end else if (cmd_valid) begin
      if (cmd_op == PUSH) begin
        m_busy = 1'b1; m_rv = 1'b1; m_data = 12'h000;
        if (stk.size() < DEPTH) begin stk.push_back(cmd_data); m_err = 1'b0; end
        else m_err = 1'b1;
      end else if (cmd_op == POP || cmd_op == PEEK) begin
        m_busy = 1'b1;
        if (stk.size() == 0) begin
          m_rv = 1'b1; m_data = 12'h000; m_err = 1'b1;
        end else begin
          m_wait = 1; m_addr = AW'(stk.size() - 1); m_data = stk[$]; m_err = 1'b0;
          if (cmd_op == POP) void'(stk.pop_back());
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      logic exp_we;
      exp_we = reset_n && !m_busy && cmd_valid && (cmd_op == PUSH) && (stk.size() < DEPTH);
      check("m_cmd_ready", cmd_ready, !m_busy);
      check("m_rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        check("m_rsp_data", rsp_data, m_data);
        check("m_rsp_err", rsp_err, m_err);
      end
      check("m_sp_count", sp_count, stk.size());
      check("m_full", full, stk.size() == DEPTH);
      check("m_empty", empty, stk.size() == 0);
      check("m_mem_we", mem_we, exp_we);
      if (exp_we) begin
        check("m_mem_in_address", mem_in_address, stk.size());
        check("m_mem_in_data", mem_in_data, cmd_data);
      end
      check("m_mem_out_address", mem_out_address, m_addr);
    end
  end

  // Issue one command; hold = cycles to keep rsp_ready low after rsp_valid.
  // Called and returns at posedge+1.
  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] d, input int hold,
                        output logic [DW-1:0] rdata, output logic rerr, output int lat);
    int n;
    rdata = 12'h000; rerr = 1'b0; lat = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = (hold == 0);
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 20) begin @(negedge clock); n++; end
    if (!cmd_ready) begin
      tests++; failed++;
      $display("FAIL accept_timeout: cmd_ready got 0 expected 1");
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      return;
    end
    @(posedge clock); #1;
    // Junk command stays asserted while a held response is pending.
    cmd_valid = (hold > 0); cmd_op = PUSH; cmd_data = 12'hABC;
    if (op == NOP) begin
      cmd_valid = 1'b0;
      return;
    end
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid && n < 10);
    lat = n;
    if (!rsp_valid) begin
      tests++; failed++;
      $display("FAIL rsp_timeout: rsp_valid got 0 expected 1");
    end
    rdata = rsp_data; rerr = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic reset_dut();
    cmd_valid = 1'b0; rsp_ready = 1'b1; reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          re;
    int            lat;
    logic [DW-1:0] pushes [3];
    logic [DW-1:0] pops   [3];
    pushes[0] = 12'h0A1; pushes[1] = 12'h0B2; pushes[2] = 12'h0C3;
    pops[0]   = 12'h0C3; pops[1]   = 12'h0B2; pops[2]   = 12'h0A1;

    @(posedge clock); #1;
    chk_en = 1'b1;
    reset_dut();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_sp_count", sp_count, 9'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_mem_out_address", mem_out_address, 8'd0);

    // Three pushes, one-cycle response latency.
    for (int i = 0; i < 3; i++) begin
      do_cmd(PUSH, pushes[i], 0, rd, re, lat);
      check("push_err", re, 1'b0);
      check("push_data", rd, 12'h000);
      check("push_lat", lat, 1);
    end
    check("push_sp_count", sp_count, 9'd3);

    do_cmd(PEEK, 12'h000, 0, rd, re, lat);
    check("peek_data", rd, 12'h0C3);
    check("peek_lat", lat, 2);
    check("peek_sp_count", sp_count, 9'd3);

    do_cmd(NOP, 12'h777, 0, rd, re, lat);
    check("nop_sp_count", sp_count, 9'd3);

    // Pops return LIFO order with two-cycle latency.
    for (int i = 0; i < 3; i++) begin
      do_cmd(POP, 12'h000, 0, rd, re, lat);
      check("pop_data", rd, pops[i]);
      check("pop_err", re, 1'b0);
      check("pop_lat", lat, 2);
    end
    check("pop_empty", empty, 1'b1);

    // Underflow on POP and PEEK.
    do_cmd(POP, 12'h000, 0, rd, re, lat);
    check("uflow_pop_err", re, 1'b1);
    check("uflow_pop_data", rd, 12'h000);
    check("uflow_pop_lat", lat, 1);
    do_cmd(PEEK, 12'h000, 0, rd, re, lat);
    check("uflow_peek_err", re, 1'b1);
    check("uflow_peek_data", rd, 12'h000);
    check("uflow_sp_count", sp_count, 9'd0);
    check("uflow_mem_out_address", mem_out_address, 8'd0);

    // Back-pressure: response held five cycles while a junk command waits.
    do_cmd(PUSH, 12'h055, 0, rd, re, lat);
    do_cmd(POP, 12'h000, 5, rd, re, lat);
    check("hold_data", rd, 12'h055);
    check("hold_sp_count", sp_count, 9'd0);

    // Fill to capacity, then overflow and peek the top.
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(PUSH, DW'(i), 0, rd, re, lat);
    end
    check("fill_err_last", re, 1'b0);
    check("fill_full", full, 1'b1);
    check("fill_sp_count", sp_count, 9'd256);
    do_cmd(PUSH, 12'hFFF, 0, rd, re, lat);
    check("oflow_err", re, 1'b1);
    check("oflow_data", rd, 12'h000);
    check("oflow_sp_count", sp_count, 9'd256);
    do_cmd(PEEK, 12'h000, 0, rd, re, lat);
    check("full_peek_data", rd, 12'h0FF);
    check("full_peek_mem_out_address", mem_out_address, 8'hFF);
    check("full_peek_sp_count", sp_count, 9'd256);

    // Reset while a PUSH response is pending.
    reset_dut();
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 12'h123; rsp_ready = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    check("r26_rsp_valid_pending", rsp_valid, 1'b1);
    check("r26_sp_count_pending", sp_count, 9'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clock);
    check("r26_rsp_valid", rsp_valid, 1'b0);
    check("r26_sp_count", sp_count, 9'd0);
    check("r26_empty", empty, 1'b1);
    @(posedge clock); #1;

    // Normal operation resumes after reset.
    do_cmd(PUSH, 12'h321, 0, rd, re, lat);
    do_cmd(POP, 12'h000, 0, rd, re, lat);
    check("post_rst_pop_data", rd, 12'h321);
    check("post_rst_empty", empty, 1'b1);

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 12, stack word width; ADDR_WIDTH, default 8, stack address width; depth is 2^ADDR_WIDTH words.
REQ-002 Ports SHALL be, in order:
  clock  in  1  single clock, all state updates on rising edge
  reset_n  in  1  synchronous, active-low reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  block can accept a command
  cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK
  cmd_data  in  DATA_WIDTH  push payload
  rsp_valid  out  1  response available
  rsp_ready  in  1  consumer takes response
  rsp_data  out  DATA_WIDTH  popped/peeked word, 0 for PUSH or error
  rsp_err  out  1  overflow (PUSH when full) or underflow (POP/PEEK when empty)
  mem_we  out  1  stack memory write enable
  mem_in_address  out  ADDR_WIDTH  stack memory write address
  mem_in_data  out  DATA_WIDTH  stack memory write data
  mem_out_address  out  ADDR_WIDTH  stack memory read address, registered
  mem_out_data  in  DATA_WIDTH  stack memory read data, combinational from mem_out_address
  sp_count  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH
  full  out  1  sp_count == 2^ADDR_WIDTH
  empty  out  1  sp_count == 0

Function
REQ-003 Accept SHALL occur on a rising edge where cmd_valid && cmd_ready.
REQ-004 FSM states SHALL be IDLE, READ, RESP; cmd_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-005 IDLE, accept NOP: no memory access, no response, remain IDLE.
REQ-006 IDLE, accept PUSH, not full: mem_we = 1 combinationally in the accept cycle, mem_in_address = sp_count[ADDR_WIDTH-1:0], mem_in_data = cmd_data; sp_count += 1 on that edge; rsp_data <= 0, rsp_err <= 0; next state RESP.
REQ-007 IDLE, accept PUSH, full: mem_we = 0, sp_count unchanged, rsp_data <= 0, rsp_err <= 1; next RESP.
REQ-008 IDLE, accept POP, not empty: mem_out_address <= sp_count-1, sp_count -= 1; next READ.
REQ-009 IDLE, accept PEEK, not empty: mem_out_address <= sp_count-1, sp_count unchanged; next READ.
REQ-010 IDLE, accept POP/PEEK, empty: no change to sp_count or mem_out_address; rsp_data <= 0, rsp_err <= 1; next RESP.
REQ-011 READ: rsp_data <= mem_out_data, rsp_err <= 0; next RESP (unconditional, one cycle).
REQ-012 RESP: rsp_data/rsp_err SHALL hold stable; on rsp_ready go IDLE, else stay RESP.
REQ-013 Latency SHALL be: PUSH or any error -> rsp_valid 1 cycle after accept; successful POP/PEEK -> 2 cycles after accept; next command accepted no earlier than 1 cycle after response taken.
REQ-014 mem_we SHALL be 0 in every cycle other than a non-full PUSH accept in IDLE, and 0 whenever reset_n = 0.
REQ-015 mem_out_address SHALL hold its last value when not updated by REQ-008/009.
REQ-016 full and empty SHALL be combinational decodes of sp_count; sp_count SHALL never exceed 2^ADDR_WIDTH nor go below 0.
REQ-017 PUSH at sp_count = 2^ADDR_WIDTH-1 SHALL write address 2^ADDR_WIDTH-1 and set full; no address wrap.
REQ-018 cmd_op and cmd_data SHALL be ignored when not accepted.

Reset
REQ-019 With reset_n = 0 at a rising edge: state IDLE, sp_count 0, rsp_valid 0, rsp_data 0, rsp_err 0, mem_out_address 0; hence empty 1, full 0, cmd_ready 1 after release.
REQ-020 Reset in READ or RESP SHALL discard the pending response; memory contents are not cleared.

Verification
REQ-021 Reset, PUSH 0x0A1, 0x0B2, 0x0C3 -> writes at addresses 0,1,2, sp_count 3, each rsp_err 0, rsp_data 0, rsp_valid 1 cycle after accept.
REQ-022 Then POP, POP, POP -> rsp_data 0x0C3, 0x0B2, 0x0A1, rsp_valid 2 cycles after each accept, final empty 1.
REQ-023 From empty, POP and PEEK -> rsp_err 1, rsp_data 0, sp_count stays 0, mem_out_address unchanged.
REQ-024 Fill 256 words with PUSH i -> full 1 at sp_count 256; PUSH 0xFFF -> rsp_err 1, mem_we never asserted, PEEK returns 0x0FF, sp_count 256.
REQ-025 rsp_ready held 0 for 5 cycles after a POP -> rsp_valid, rsp_data stable, cmd_ready 0 throughout; cmd_valid asserted meanwhile not accepted.
REQ-026 reset_n = 0 for one cycle while in RESP after PUSH -> rsp_valid 0, sp_count 0, empty 1 on the next cycle.
